// File: rtl/pulse_frame_pkg.sv
// Shared types and helpers for the pulse frame builder.
// Contents: frame FSM state enum, index-width helper, trailer truncation-bit position.
package pulse_frame_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PRE,
      HDR,
      PAY,
      TRL,
      GAP
   } frame_state_t;

   // Width of an index that counts 0..n-1; never narrower than one bit.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Trailer bit carrying the truncation flag (TRUNC_BIT = DATA_W-1).
   function automatic int unsigned trunc_bit(input int unsigned data_w);
      return data_w - 1;
   endfunction

endpackage

// File: rtl/pulse_frame_builder_counter.sv
// Noise gate plus pulse counter for one frame.
// Ports: clk_25m/rst clock and async active-high reset; clr restarts the count
// and re-arms; en marks a consumed sample; mode 0 counts gated samples,
// mode 1 counts hysteretic pulses; gated_sample is the combinational gate result;
// count is the registered saturating count.
module pulse_counter #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned CNT_W  = 8
) (
   input  logic              clk_25m,
   input  logic              rst,
   input  logic              clr,
   input  logic              en,
   input  logic              mode,
   input  logic [DATA_W-1:0] sample,
   input  logic [DATA_W-1:0] noise_thr,
   input  logic [DATA_W-1:0] pulse_thr,
   output logic [DATA_W-1:0] gated_sample,
   output logic [CNT_W-1:0]  count
);

   logic pass_c;
   logic pulse_hit_c;
   logic at_max_c;
   logic armed;

   assign pass_c       = (sample >= noise_thr);
   assign pulse_hit_c  = (sample >= pulse_thr);
   assign at_max_c     = (count == {CNT_W{1'b1}});
   assign gated_sample = pass_c ? sample : '0;

   // Counter saturates instead of wrapping; armed re-opens once the signal drops below the gate.
   always_ff @(posedge clk_25m or posedge rst) begin
      if (rst) begin
         count <= '0;
         armed <= 1'b1;
      end else if (clr) begin
         count <= '0;
         armed <= 1'b1;
      end else if (en) begin
         if (!mode) begin
            if (pass_c && !at_max_c) count <= count + CNT_W'(1);
         end else if (armed && pulse_hit_c) begin
            if (!at_max_c) count <= count + CNT_W'(1);
            armed <= 1'b0;
         end else if (!pass_c) begin
            armed <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/pulse_frame_builder.sv
// Frames one burst per data_flag rising edge: zero padding, channel header,
// noise-gated payload and a trailer holding {truncated, pulse count}.
// Ports: clk_25m/rst clock and async active-high reset; cfg_load with
// noise_threshold/pulse_threshold/count_mode feeds the shadow config;
// data_in/data_flag sample stream and burst level; channel_number header id;
// data_out/wr_ram_flag registered RAM write word and strobe; sof/eof strobes
// on the header and trailer words.
module pulse_frame_builder
   import pulse_frame_pkg::*;
#(
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned CH_W      = 4,
   parameter int unsigned CNT_W     = 8,
   parameter int unsigned SAMPLES   = 128,
   parameter int unsigned PRE_ZEROS = 5,
   parameter int unsigned PASS_THRU = 1
) (
   input  logic              clk_25m,
   input  logic              rst,
   input  logic              cfg_load,
   input  logic [DATA_W-1:0] noise_threshold,
   input  logic [DATA_W-1:0] pulse_threshold,
   input  logic              count_mode,
   input  logic [DATA_W-1:0] data_in,
   input  logic              data_flag,
   input  logic [CH_W-1:0]   channel_number,
   output logic [DATA_W-1:0] data_out,
   output logic              wr_ram_flag,
   output logic              sof,
   output logic              eof
);

   localparam int unsigned PRE_W     = idx_w(PRE_ZEROS);
   localparam int unsigned PAY_W     = idx_w(SAMPLES);
   localparam int unsigned PRE_LAST  = (PRE_ZEROS > 0) ? PRE_ZEROS - 1 : 0;
   localparam int unsigned TRUNC_BIT = trunc_bit(DATA_W);

   frame_state_t      state_q, state_d;
   logic [PRE_W-1:0]  pre_cnt_q, pre_cnt_d;
   logic [PAY_W-1:0]  pay_idx_q, pay_idx_d;
   logic              flag_d;
   logic [DATA_W-1:0] shadow_noise, shadow_pulse, act_noise, act_pulse;
   logic              shadow_mode, act_mode;
   logic              start_c, cnt_clr_c, cnt_en_c;
   logic              wr_d, sof_d, eof_d;
   logic [DATA_W-1:0] out_d, idle_word_c, gated_c, trl_word_c;
   logic [CNT_W-1:0]  count;

   assign idle_word_c = (PASS_THRU != 0) ? data_in : '0;
   assign trl_word_c  = DATA_W'(count);

   pulse_counter #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
   ) u_counter (
      .clk_25m      (clk_25m),
      .rst          (rst),
      .clr          (cnt_clr_c),
      .en           (cnt_en_c),
      .mode         (act_mode),
      .sample       (data_in),
      .noise_thr    (act_noise),
      .pulse_thr    (act_pulse),
      .gated_sample (gated_c),
      .count        (count)
   );

   // State register.
   always_ff @(posedge clk_25m or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next state and next output word.
   always_comb begin
      state_d   = state_q;
      pre_cnt_d = pre_cnt_q;
      pay_idx_d = pay_idx_q;
      out_d     = idle_word_c;
      wr_d      = 1'b0;
      sof_d     = 1'b0;
      eof_d     = 1'b0;
      cnt_clr_c = 1'b0;
      cnt_en_c  = 1'b0;
      start_c   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (data_flag && !flag_d) begin
               start_c   = 1'b1;
               pre_cnt_d = '0;
               state_d   = (PRE_ZEROS == 0) ? HDR : PRE;
            end
         end
         PRE: begin
            out_d     = '0;
            pre_cnt_d = pre_cnt_q + PRE_W'(1);
            if (pre_cnt_q == PRE_W'(PRE_LAST)) state_d = HDR;
         end
         HDR: begin
            out_d     = DATA_W'(channel_number);
            wr_d      = 1'b1;
            sof_d     = 1'b1;
            cnt_clr_c = 1'b1;
            pay_idx_d = '0;
            state_d   = PAY;
         end
         PAY: begin
            wr_d = 1'b1;
            if (data_flag) begin
               out_d     = gated_c;
               cnt_en_c  = 1'b1;
               pay_idx_d = pay_idx_q + PAY_W'(1);
               if (pay_idx_q == PAY_W'(SAMPLES - 1)) state_d = TRL;
            end else begin
               // Dropped burst: this edge becomes the trailer, flagged truncated.
               out_d            = trl_word_c;
               out_d[TRUNC_BIT] = 1'b1;
               eof_d            = 1'b1;
               state_d          = GAP;
            end
         end
         TRL: begin
            out_d   = trl_word_c;
            wr_d    = 1'b1;
            eof_d   = 1'b1;
            state_d = GAP;
         end
         GAP: begin
            if (!data_flag) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Output, index and configuration registers; new shadow values are forwarded on the start edge.
   always_ff @(posedge clk_25m or posedge rst) begin
      if (rst) begin
         pre_cnt_q    <= '0;
         pay_idx_q    <= '0;
         flag_d       <= 1'b0;
         data_out     <= '0;
         wr_ram_flag  <= 1'b0;
         sof          <= 1'b0;
         eof          <= 1'b0;
         shadow_noise <= '0;
         shadow_pulse <= '0;
         shadow_mode  <= 1'b0;
         act_noise    <= '0;
         act_pulse    <= '0;
         act_mode     <= 1'b0;
      end else begin
         pre_cnt_q   <= pre_cnt_d;
         pay_idx_q   <= pay_idx_d;
         flag_d      <= data_flag;
         data_out    <= out_d;
         wr_ram_flag <= wr_d;
         sof         <= sof_d;
         eof         <= eof_d;
         if (cfg_load) begin
            shadow_noise <= noise_threshold;
            shadow_pulse <= pulse_threshold;
            shadow_mode  <= count_mode;
         end
         if (start_c) begin
            act_noise <= cfg_load ? noise_threshold : shadow_noise;
            act_pulse <= cfg_load ? pulse_threshold : shadow_pulse;
            act_mode  <= cfg_load ? count_mode      : shadow_mode;
         end
      end
   end

endmodule

// File: tb/tb_pulse_frame_builder.sv
// Self-checking bench: two builder instances (default parameters, and a short
// unpadded, non-pass-through, 4-bit-counter variant) share one stimulus stream.
// A frame-position model predicts every output word; directed scenarios are
// also pinned with hand-computed literals.
module tb_pulse_frame_builder;

   localparam int P_A = 5, S_A = 128, CW_A = 8, PT_A = 1;
   localparam int P_B = 0, S_B = 20,  CW_B = 4, PT_B = 0;

   logic        clk_25m = 1'b0;
   logic        rst = 1'b1;
   logic        cfg_load = 1'b0;
   logic        count_mode = 1'b0;
   logic        data_flag = 1'b0;
   logic [15:0] noise_threshold = '0;
   logic [15:0] pulse_threshold = '0;
   logic [15:0] data_in = '0;
   logic [3:0]  channel_number = '0;

   logic [15:0] dout_a, dout_b;
   logic        wr_a, wr_b, sof_a, sof_b, eof_a, eof_b;

   int checks = 0;
   int errors = 0;

   always #20 clk_25m = ~clk_25m;

   pulse_frame_builder #(.DATA_W(16), .CH_W(4), .CNT_W(CW_A), .SAMPLES(S_A),
                         .PRE_ZEROS(P_A), .PASS_THRU(PT_A)) dut_a (
      .clk_25m(clk_25m), .rst(rst), .cfg_load(cfg_load),
      .noise_threshold(noise_threshold), .pulse_threshold(pulse_threshold),
      .count_mode(count_mode), .data_in(data_in), .data_flag(data_flag),
      .channel_number(channel_number), .data_out(dout_a),
      .wr_ram_flag(wr_a), .sof(sof_a), .eof(eof_a));

   pulse_frame_builder #(.DATA_W(16), .CH_W(4), .CNT_W(CW_B), .SAMPLES(S_B),
                         .PRE_ZEROS(P_B), .PASS_THRU(PT_B)) dut_b (
      .clk_25m(clk_25m), .rst(rst), .cfg_load(cfg_load),
      .noise_threshold(noise_threshold), .pulse_threshold(pulse_threshold),
      .count_mode(count_mode), .data_in(data_in), .data_flag(data_flag),
      .channel_number(channel_number), .data_out(dout_b),
      .wr_ram_flag(wr_b), .sof(sof_b), .eof(eof_b));

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, got, exp);
      end
   endtask

   // ---------------- model: frame position since the start edge ----------------
   bit          m_inf[2], m_gap[2], m_pflag[2];
   int          m_pos[2], m_ncons[2];
   logic [15:0] m_shn[2], m_shp[2], m_an[2], m_ap[2];
   bit          m_shm[2], m_am[2];
   logic [15:0] m_cons[2][128];
   logic [15:0] exp_d[2];
   bit          exp_w[2], exp_s[2], exp_e[2];

   // Trailer word from the list of consumed samples of the current frame.
   function automatic logic [15:0] trailer_word(input int i, input int cw, input bit trunc);
      int unsigned c;
      int unsigned maxc;
      bit          armed;
      logic [15:0] smp;
      c = 0;
      armed = 1'b1;
      maxc = (32'd1 << cw) - 1;
      for (int k = 0; k < m_ncons[i]; k++) begin
         smp = m_cons[i][k];
         if (!m_am[i]) begin
            if (smp >= m_an[i]) c++;
         end else if (armed && smp >= m_ap[i]) begin
            c++;
            armed = 1'b0;
         end else if (smp < m_an[i]) begin
            armed = 1'b1;
         end
      end
      if (c > maxc) c = maxc;
      return {trunc, 15'(c)};
   endfunction

   task automatic model_edge(input int i);
      int p, ns, cw, pt, k;
      logic [15:0] idle;
      p  = (i == 0) ? P_A  : P_B;
      ns = (i == 0) ? S_A  : S_B;
      cw = (i == 0) ? CW_A : CW_B;
      pt = (i == 0) ? PT_A : PT_B;
      exp_d[i] = '0; exp_w[i] = 0; exp_s[i] = 0; exp_e[i] = 0;
      if (rst) begin
         m_inf[i] = 0; m_gap[i] = 0; m_pflag[i] = 0;
         m_shn[i] = '0; m_shp[i] = '0; m_shm[i] = 0;
         m_an[i] = '0; m_ap[i] = '0; m_am[i] = 0;
         return;
      end
      idle = (pt != 0) ? data_in : 16'd0;
      if (!m_inf[i]) begin
         exp_d[i] = idle;
         if (data_flag && !m_pflag[i]) begin
            m_inf[i] = 1; m_gap[i] = 0; m_pos[i] = 0; m_ncons[i] = 0;
            m_an[i] = cfg_load ? noise_threshold : m_shn[i];
            m_ap[i] = cfg_load ? pulse_threshold : m_shp[i];
            m_am[i] = cfg_load ? count_mode      : m_shm[i];
         end
      end else if (m_gap[i]) begin
         exp_d[i] = idle;
         if (!data_flag) m_inf[i] = 0;
      end else begin
         m_pos[i]++;
         k = m_pos[i] - p - 2;
         if (m_pos[i] <= p) begin
            exp_d[i] = '0;
         end else if (m_pos[i] == p + 1) begin
            exp_d[i] = 16'(channel_number); exp_w[i] = 1; exp_s[i] = 1;
         end else if (k == ns || !data_flag) begin
            exp_d[i] = trailer_word(i, cw, k != ns);
            exp_w[i] = 1; exp_e[i] = 1; m_gap[i] = 1;
         end else begin
            m_cons[i][m_ncons[i]] = data_in;
            m_ncons[i]++;
            exp_d[i] = (data_in >= m_an[i]) ? data_in : 16'd0;
            exp_w[i] = 1;
         end
      end
      if (cfg_load) begin
         m_shn[i] = noise_threshold; m_shp[i] = pulse_threshold; m_shm[i] = count_mode;
      end
      m_pflag[i] = data_flag;
   endtask

   // ---------------- per-cycle compare and observation ----------------
   logic [15:0] hdr_a = '0, trl_a = '0, trl_b = '0;
   int          nsof_a = 0, nsof_b = 0, run_a = 0, run_last_a = 0;
   logic [15:0] pay_log_a[$];

   always @(posedge clk_25m) begin
      model_edge(0);
      model_edge(1);
      #1;
      chk("cycle_a", 32'({dout_a, wr_a, sof_a, eof_a}), 32'({exp_d[0], exp_w[0], exp_s[0], exp_e[0]}));
      chk("cycle_b", 32'({dout_b, wr_b, sof_b, eof_b}), 32'({exp_d[1], exp_w[1], exp_s[1], exp_e[1]}));
      if (wr_a) run_a++; else run_a = 0;
      if (sof_a) begin nsof_a++; hdr_a = dout_a; pay_log_a.delete(); end
      if (eof_a) begin trl_a = dout_a; run_last_a = run_a; end
      if (wr_a && !sof_a && !eof_a) pay_log_a.push_back(dout_a);
      if (sof_b) nsof_b++;
      if (eof_b) trl_b = dout_b;
   end

   // ---------------- stimulus ----------------
   logic [15:0] pat[256];
   int          cfg_at = -1;
   logic [15:0] cfg_nv = '0;

   task automatic load_cfg(input logic [15:0] n, input logic [15:0] p, input logic m);
      @(negedge clk_25m);
      cfg_load = 1; noise_threshold = n; pulse_threshold = p; count_mode = m;
      @(negedge clk_25m);
      cfg_load = 0;
   endtask

   task automatic fill(input logic [15:0] v);
      for (int c = 0; c < 256; c++) pat[c] = v;
   endtask

   task automatic burst(input int hold, input int tail);
      for (int c = 0; c < hold; c++) begin
         @(negedge clk_25m);
         data_flag = 1; data_in = pat[c];
         cfg_load = (c == cfg_at);
         if (c == cfg_at) noise_threshold = cfg_nv;
      end
      for (int c = 0; c < tail; c++) begin
         @(negedge clk_25m);
         data_flag = 0; cfg_load = 0; data_in = 16'h1234;
      end
      cfg_at = -1;
   endtask

   initial begin
      int na, nb;
      repeat (3) @(negedge clk_25m);
      chk("reset_a", 32'({dout_a, wr_a, sof_a, eof_a}), 32'h0);
      chk("reset_b", 32'({dout_b, wr_b, sof_b, eof_b}), 32'h0);
      rst = 0;
      channel_number = 4'd3;

      // Level mode: 64 x 50 then 64 x 150 at noise 100.
      load_cfg(16'd100, 16'd0, 1'b0);
      for (int c = 0; c < 256; c++) pat[c] = (c < 71) ? 16'd50 : 16'd150;
      burst(140, 3);
      chk("lvl_hdr", 32'(hdr_a), 32'h0003);
      chk("lvl_trl", 32'(trl_a), 32'h0040);
      chk("lvl_wr_run", 32'(run_last_a), 32'd130);
      chk("lvl_pay0", 32'(pay_log_a[0]), 32'h0000);
      chk("lvl_pay63", 32'(pay_log_a[63]), 32'h0000);
      chk("lvl_pay64", 32'(pay_log_a[64]), 32'h0096);
      chk("lvl_pay127", 32'(pay_log_a[127]), 32'h0096);

      // Pulse mode with hysteresis.
      load_cfg(16'd100, 16'd500, 1'b1);
      fill(16'd0);
      pat[7] = 16'd600; pat[8] = 16'd600; pat[9] = 16'd50;
      pat[10] = 16'd600; pat[11] = 16'd200; pat[12] = 16'd600;
      burst(140, 3);
      chk("pls_trl", 32'(trl_a), 32'h0002);
      chk("pls_p0", 32'(pay_log_a[0]), 32'd600);
      chk("pls_p2", 32'(pay_log_a[2]), 32'd0);
      chk("pls_p4", 32'(pay_log_a[4]), 32'd200);
      chk("pls_p5", 32'(pay_log_a[5]), 32'd600);

      // Truncation after 10 payload samples, then a fresh frame.
      load_cfg(16'd100, 16'd500, 1'b0);
      fill(16'd300);
      burst(17, 3);
      chk("trunc_trl", 32'(trl_a), 32'h800A);
      chk("trunc_trl_b", 32'(trl_b), 32'h800F);
      na = nsof_a;
      burst(140, 3);
      chk("trunc_refr", 32'(nsof_a), 32'(na + 1));
      chk("trunc_refr_trl", 32'(trl_a), 32'h0080);

      // Saturation (4-bit counter) and no retrigger while held high.
      na = nsof_a; nb = nsof_b;
      burst(160, 3);
      chk("sat_trl_b", 32'(trl_b), 32'h000F);
      chk("sat_one_b", 32'(nsof_b), 32'(nb + 1));
      chk("sat_one_a", 32'(nsof_a), 32'(na + 1));

      // Shadow load mid-payload affects only the next frame.
      load_cfg(16'd100, 16'd500, 1'b0);
      fill(16'd150);
      cfg_at = 40; cfg_nv = 16'd200;
      burst(140, 3);
      chk("shd_cur_trl", 32'(trl_a), 32'h0080);
      chk("shd_cur_p127", 32'(pay_log_a[127]), 32'h0096);
      burst(140, 3);
      chk("shd_nxt_p0", 32'(pay_log_a[0]), 32'h0000);
      chk("shd_nxt_trl", 32'(trl_a), 32'h0000);
      cfg_at = 0; cfg_nv = 16'd120;
      burst(140, 3);
      chk("shd_fwd_trl", 32'(trl_a), 32'h0080);
      chk("shd_fwd_p0", 32'(pay_log_a[0]), 32'h0096);

      // Reset mid-payload: immediate clear, then silence until a new rising edge.
      fill(16'd300);
      for (int c = 0; c < 20; c++) begin
         @(negedge clk_25m);
         data_flag = 1; data_in = pat[c];
      end
      na = nsof_a;
      @(negedge clk_25m);
      rst = 1; data_flag = 0; data_in = '0;
      #1;
      chk("rst_now_a", 32'({dout_a, wr_a, sof_a, eof_a}), 32'h0);
      chk("rst_now_b", 32'({dout_b, wr_b, sof_b, eof_b}), 32'h0);
      repeat (2) @(negedge clk_25m);
      rst = 0;
      repeat (10) @(negedge clk_25m);
      chk("rst_quiet_sof", 32'(nsof_a), 32'(na));
      chk("rst_quiet_out", 32'({dout_a, wr_a}), 32'h0);

      // Randomized traffic against the model.
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk_25m);
         cfg_load = ($urandom_range(0, 39) == 0);
         if (cfg_load) begin
            noise_threshold = 16'($urandom_range(0, 700));
            pulse_threshold = 16'($urandom_range(0, 700));
            count_mode      = 1'($urandom_range(0, 1));
         end
         if (data_flag) begin
            if ($urandom_range(0, 149) == 0) data_flag = 0;
         end else if ($urandom_range(0, 7) == 0) begin
            data_flag = 1;
         end
         data_in = 16'($urandom_range(0, 800));
         if ($urandom_range(0, 15) == 0) channel_number = 4'($urandom);
         rst = ($urandom_range(0, 1499) == 0);
      end
      @(negedge clk_25m);
      rst = 0; data_flag = 0; cfg_load = 0;
      repeat (4) @(negedge clk_25m);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pulse_frame_builder.md
Name: pulse_frame_builder

Overview:
Parametrised successor of the per-channel frame formatter, sitting between the acquisition front end and the channel RAM writer. On each rising edge of data_flag it frames one burst: PRE_ZEROS padding words, a channel header word, SAMPLES payload words with noise-gated samples, and a trailer word carrying the pulse count plus a truncation bit. It adds the following over the earlier generation:
- a selectable pulse-counting mode with hysteresis;
- shadowed threshold loading;
- early termination on a dropped data_flag;
- sof/eof strobes;
- a saturating counter.

Parameters:
DATA_W, 16, sample and output word width
CH_W, 4, channel number width (CH_W <= DATA_W)
CNT_W, 8, pulse counter width (CNT_W <= DATA_W-1)
SAMPLES, 128, payload words per frame (>= 1)
PRE_ZEROS, 5, zero padding words before the header (>= 0)
PASS_THRU, 1, 1: data_out follows data_in when IDLE; 0: data_out is 0 when IDLE

Ports:
clk_25m  in  1  system clock; all logic on its rising edge
rst  in  1  asynchronous, active-high reset
cfg_load  in  1  latch noise_threshold, pulse_threshold and count_mode into the shadow registers
noise_threshold  in  DATA_W  gate threshold; a sample >= this value is passed
pulse_threshold  in  DATA_W  pulse detection threshold (count_mode=1)
count_mode  in  1  0: count gated samples; 1: count hysteretic pulses
data_in  in  DATA_W  sample stream
data_flag  in  1  burst-valid level from the acquisition logic
channel_number  in  CH_W  channel id placed in the header
data_out  out  DATA_W  registered output word
wr_ram_flag  out  1  data_out is a header, payload or trailer word
sof  out  1  one-cycle strobe with the header word
eof  out  1  one-cycle strobe with the trailer word

Behaviour:
- Reset state. All outputs are 0. FSM=IDLE. Shadow and active thresholds are 0, count_mode=0, counter=0, armed=1, flag_d=0. Reset takes effect immediately at any point, including mid-frame; no partial trailer is emitted.
- Shadow registers. cfg_load updates the shadow registers on any cycle. The active copy loads from the shadow registers only on the frame-start edge. A cfg_load on that same edge is applied to that frame, because the new shadow value is forwarded.
- Start condition. In IDLE, when data_flag=1 and flag_d=0 (rising edge), the FSM enters PRE, or HDR if PRE_ZEROS=0. flag_d is the previous-cycle data_flag.
- PRE. Runs PRE_ZEROS cycles. data_out=0, wr_ram_flag=0, data_in ignored.
- HDR. Runs one cycle. data_out={zeros, channel_number} sampled on this edge, wr_ram_flag=1, sof=1. Counter cleared, armed=1.
- PAY. Runs up to SAMPLES cycles. Each edge with data_flag=1 consumes data_in:
  - data_out = data_in if data_in >= noise_active, else 0; wr_ram_flag=1.
  - Latency is one register stage.
  - A payload index counts 0..SAMPLES-1. After index SAMPLES-1, go to TRL.
- Counting, mode 0. counter++ when data_in >= noise_active.
- Counting, mode 1.
  - If armed and data_in >= pulse_active: counter++ and armed=0.
  - Otherwise, if data_in < noise_active: armed=1.
  - If pulse_active < noise_active, the compare still works as specified; no special casing.
- Counter limit. The counter saturates at 2^CNT_W-1 and never wraps.
- Truncation. On a PAY edge with data_flag=0, no sample is consumed. That edge emits the trailer directly with truncated=1.
- TRL. Runs one cycle. data_out={truncated, zeros, counter}, wr_ram_flag=1, eof=1. Then go to GAP.
- GAP.
  - data_out follows the IDLE rule and wr_ram_flag=0.
  - Stay in GAP while data_flag=1; go to IDLE when data_flag=0.
  - A burst held high past the trailer does not retrigger.
- Before payload. If data_flag falls during PRE or HDR, the frame still proceeds to PAY. The first PAY edge then truncates, giving trailer count 0 with truncated=1.
- IDLE output. data_out <= data_in if PASS_THRU=1, else 0. wr_ram_flag, sof and eof are 0.
- Frame length. An untruncated frame is PRE_ZEROS+SAMPLES+2 output cycles. wr_ram_flag is high for exactly SAMPLES+2 of them, contiguous.

Decomposition:
- Package pulse_frame_pkg holds:
  - the state enum (IDLE, PRE, HDR, PAY, TRL, GAP);
  - the trailer bit position constant TRUNC_BIT=DATA_W-1;
  - the clog2-derived index widths.
- Sub-module pulse_counter holds the gate compare, armed flag and saturating counter. Its ports are clk_25m, rst, clr, en, mode, sample, noise_thr, pulse_thr, gated_sample, count.

Test Plan:
- Reset: assert rst mid-PAY -> data_out=0, wr_ram_flag=0, sof=eof=0 immediately. After release, no output until a new data_flag rising edge.
- Level mode, default params, noise=100, channel=3. Input: 64 samples of 50, then 64 of 150.
  - Output: 5 zeros with wr_ram_flag=0, then 0x0003 with sof.
  - Then 64 x 0x0000 and 64 x 0x0096.
  - Then trailer 0x0040 with eof; wr_ram_flag high 130 cycles.
- Pulse mode, noise=100, pulse=500. Payload starts 600,600,50,600,200,600, rest 0.
  - Outputs are 600,600,0,600,200,600.
  - Trailer count=2.
- Truncation: drop data_flag after 10 payload samples all >= noise.
  - Next word is trailer 0x800A with eof.
  - Holding data_flag low then high starts a fresh frame.
- Saturation and retrigger, CNT_W=4, all samples >= noise.
  - Trailer count is 0x000F.
  - data_flag held high 20 cycles past the trailer -> no second frame.
- Shadow load: cfg_load noise 100->200 mid-PAY.
  - The current frame gates at 100.
  - The next frame gates at 200; a sample of 150 gives 0.
